// File: rtl/keyboard_fifo_wb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_fifo_wb_if : Wishbone slave port bundle for the keyboard FIFO block
// rev 1.0
// ---------------------------------------------------------------------------
interface keyboard_fifo_wb_if;
  logic [15:0] wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic        wb_stb;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_dat_i, wb_cyc, wb_we, wb_sel, wb_stb,
    input  wb_dat_o, wb_ack
  );

  modport slave (
    input  wb_adr, wb_dat_i, wb_cyc, wb_we, wb_sel, wb_stb,
    output wb_dat_o, wb_ack
  );
endinterface
`default_nettype wire

// File: rtl/keyboard_fifo_wb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_fifo_wb : Wishbone keyboard registers with key FIFO, autorepeat
//                    and vectored interrupt requests (60 / 274)
// rev 1.0
// ---------------------------------------------------------------------------
module keyboard_fifo_wb #(
  parameter int unsigned DEPTH         = 8,
  parameter logic [15:0] BASE_ADDR     = 16'o177660,
  parameter logic [23:0] REPEAT_DELAY  = 24'd12000000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd2400000
) (
  input  wire logic                     wb_clk,
  input  wire logic                     sys_init_n,
  keyboard_fifo_wb_if.slave             wb,
  input  wire logic                     key_valid,
  input  wire logic [6:0]               key_code,
  input  wire logic                     key_ar2,
  input  wire logic                     key_release,
  output logic                          virq_req60,
  input  wire logic                     virq_ack60,
  output logic                          virq_req274,
  input  wire logic                     virq_ack274,
  output logic                          key_down,
  output logic [$clog2(DEPTH):0]        fifo_level
);

  localparam int unsigned c_aw        = $clog2(DEPTH);
  localparam logic [15:0] c_data_addr = BASE_ADDR + 16'd2;
  localparam logic [c_aw:0] c_full_lvl = (c_aw+1)'(DEPTH);
  localparam bit          c_rep_en    = (REPEAT_DELAY != 24'd0);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic            r_mask, r_ovf, r_armed;
  logic            r_req60, r_req274;
  logic            r_hit_d, r_ack0, r_ack1;
  logic            r_ack60_d, r_ack274_d;
  logic [15:0]     r_rdata;
  logic            r_key_down;
  logic [23:0]     r_rep_cnt;
  logic [7:0]      r_rep_entry;

  logic            w_sel_st, w_sel_dt, w_sel, w_hit, w_edge;
  logic            w_empty, w_full, w_pop, w_st_wr;
  logic            w_press, w_rep_fire, w_push_req, w_push, w_drop_ovf;
  logic [7:0]      w_push_data, w_head;
  logic [c_aw:0]   w_level_next;
  logic            w_new_head, w_raise, w_ack60_rise, w_ack274_rise;
  logic [15:0]     w_status;
  logic            w_unused;

  // Bus decode: the data register only answers reads.
  assign w_sel_st = wb.wb_cyc && (wb.wb_adr[15:1] == BASE_ADDR[15:1]);
  assign w_sel_dt = wb.wb_cyc && (wb.wb_adr[15:1] == c_data_addr[15:1]) && !wb.wb_we;
  assign w_sel    = w_sel_st || w_sel_dt;
  assign w_hit    = wb.wb_stb && w_sel;
  assign w_edge   = w_hit && !r_hit_d;

  assign wb.wb_ack   = w_hit && (wb.wb_we || r_ack1);
  assign wb.wb_dat_o = (w_sel && !wb.wb_we) ? r_rdata : 16'd0;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == c_full_lvl);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_status = {r_ovf, 7'd0, !w_empty, r_mask, 6'd0};
  assign w_pop    = w_edge && w_sel_dt && !w_empty;
  assign w_st_wr  = w_edge && w_sel_st && wb.wb_we;

  // A fresh press outranks a repeat expiry; a repeat never flags overflow.
  assign w_press     = key_valid && (key_code != 7'd0);
  assign w_rep_fire  = c_rep_en && r_key_down && (r_rep_cnt == 24'd1) && !w_press && !key_release;
  assign w_push_req  = w_press || w_rep_fire;
  assign w_push_data = w_press ? {key_ar2, key_code} : r_rep_entry;
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_drop_ovf  = w_press && w_full && !w_pop;

  assign w_level_next = r_level + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
  assign w_new_head   = (w_push && w_empty) || (w_pop && (w_level_next != '0));
  assign w_raise      = r_armed && !r_mask && !r_req60 && !r_req274 && !w_empty;
  assign w_ack60_rise  = virq_ack60 && !r_ack60_d;
  assign w_ack274_rise = virq_ack274 && !r_ack274_d;

  assign virq_req60  = r_req60;
  assign virq_req274 = r_req274;
  assign key_down    = r_key_down;
  assign fifo_level  = r_level;

  assign w_unused = &{1'b0, wb.wb_sel, wb.wb_dat_i[14:7], wb.wb_dat_i[5:0], wb.wb_adr[0]};

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge wb_clk or negedge sys_init_n) begin
    if (!sys_init_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_mask      <= 1'b1;
      r_ovf       <= 1'b0;
      r_armed     <= 1'b0;
      r_req60     <= 1'b0;
      r_req274    <= 1'b0;
      r_hit_d     <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_ack60_d   <= 1'b0;
      r_ack274_d  <= 1'b0;
      r_rdata     <= 16'd0;
      r_key_down  <= 1'b0;
      r_rep_cnt   <= 24'd0;
      r_rep_entry <= 8'd0;
    end else begin
      r_hit_d    <= w_hit;
      r_ack0     <= w_hit;
      r_ack1     <= wb.wb_cyc && r_ack0;
      r_ack60_d  <= virq_ack60;
      r_ack274_d <= virq_ack274;

      // Read data is captured once at the strobe edge and held for the access.
      if (w_edge && !wb.wb_we)
        r_rdata <= w_sel_st ? w_status : {8'd0, (w_empty ? 8'd0 : w_head)};

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;

      if (w_st_wr) r_mask <= wb.wb_dat_i[6];
      if (w_st_wr && wb.wb_dat_i[15]) r_ovf <= 1'b0;
      if (w_drop_ovf) r_ovf <= 1'b1;

      if (c_rep_en && w_press) begin
        r_rep_entry <= {key_ar2, key_code};
        r_key_down  <= 1'b1;
        r_rep_cnt   <= REPEAT_DELAY;
      end else if (key_release) begin
        r_key_down <= 1'b0;
        r_rep_cnt  <= 24'd0;
      end else if (r_key_down) begin
        r_rep_cnt <= (r_rep_cnt == 24'd1) ? REPEAT_PERIOD : r_rep_cnt - 24'd1;
      end

      if (w_new_head)   r_armed <= 1'b1;
      else if (w_raise) r_armed <= 1'b0;

      // Popping retires the pending request; the next head re-arms.
      if (w_pop) begin
        r_req60  <= 1'b0;
        r_req274 <= 1'b0;
      end else begin
        if (w_raise) begin
          if (w_head[7]) r_req274 <= 1'b1;
          else           r_req60  <= 1'b1;
        end
        if (w_ack60_rise)  r_req60  <= 1'b0;
        if (w_ack274_rise) r_req274 <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
